// File: rtl/obi_xbar_nm_pkg.sv
// Shared types and helpers for the N-master / M-slave OBI crossbar.
package obi_xbar_nm_pkg;

  localparam int unsigned RULE_IDX_W  = 32;
  localparam int unsigned RULE_ADDR_W = 32;

  // One address rule: matches when start_addr <= addr < end_addr; idx names the slave port.
  typedef struct packed {
    logic [RULE_IDX_W-1:0]  idx;
    logic [RULE_ADDR_W-1:0] start_addr;
    logic [RULE_ADDR_W-1:0] end_addr;
  } addr_rule_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The error responder sits one past the last real slave.
  function automatic int unsigned err_idx(input int unsigned nslave);
    return nslave;
  endfunction

endpackage

// File: rtl/obi_xbar_idx_fifo.sv
// Index FIFO remembering which master owns each outstanding slave transaction.
module obi_xbar_idx_fifo
  import obi_xbar_nm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = idx_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_xbar_nm.sv
// N-master to M-slave OBI crossbar: per-slave round-robin arbiters, index FIFOs for
// response routing, and an internal error responder for unmapped addresses.
module obi_xbar_nm
  import obi_xbar_nm_pkg::*;
#(
  parameter int unsigned NMASTER    = 3,
  parameter int unsigned NSLAVE     = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NSLAVE*(RULE_IDX_W+2*ADDR_WIDTH)-1:0]      addr_map_i,
  input  logic [NMASTER-1:0]                               m_req_i,
  input  logic [NMASTER-1:0]                               m_we_i,
  input  logic [NMASTER*(DATA_WIDTH/8)-1:0]                m_be_i,
  input  logic [NMASTER*ADDR_WIDTH-1:0]                    m_addr_i,
  input  logic [NMASTER*DATA_WIDTH-1:0]                    m_wdata_i,
  output logic [NMASTER-1:0]                               m_gnt_o,
  output logic [NMASTER-1:0]                               m_rvalid_o,
  output logic [NMASTER*DATA_WIDTH-1:0]                    m_rdata_o,
  output logic [NMASTER-1:0]                               m_err_o,
  output logic [NSLAVE-1:0]                                s_req_o,
  output logic [NSLAVE-1:0]                                s_we_o,
  output logic [NSLAVE*(DATA_WIDTH/8)-1:0]                 s_be_o,
  output logic [NSLAVE*ADDR_WIDTH-1:0]                     s_addr_o,
  output logic [NSLAVE*DATA_WIDTH-1:0]                     s_wdata_o,
  input  logic [NSLAVE-1:0]                                s_gnt_i,
  input  logic [NSLAVE-1:0]                                s_rvalid_i,
  input  logic [NSLAVE*DATA_WIDTH-1:0]                     s_rdata_i
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned RULE_W  = RULE_IDX_W + 2 * ADDR_WIDTH;
  localparam int unsigned MW      = idx_width(NMASTER);
  localparam int unsigned SW      = idx_width(NSLAVE + 1);
  localparam int unsigned CW      = $clog2(MAX_OUTST + 1);
  localparam int unsigned ERR_IDX = err_idx(NSLAVE);
  localparam int unsigned NT      = NSLAVE + 1;

  logic [SW-1:0]         tgt        [NMASTER];
  logic [NMASTER-1:0]    req_ok, gnt, rsp_vld, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data   [NMASTER];
  logic [CW-1:0]         cnt_q      [NMASTER];
  logic [CW-1:0]         cnt_d      [NMASTER];
  logic [SW-1:0]         last_tgt_q [NMASTER];
  logic [SW-1:0]         last_tgt_d [NMASTER];
  logic [MW-1:0]         rr_q       [NT];
  logic [MW-1:0]         rr_d       [NT];
  logic [MW-1:0]         arb_sel    [NT];
  logic [NT-1:0]         arb_vld, tgt_gnt;
  logic [NSLAVE-1:0]     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [MW-1:0]         fifo_head  [NSLAVE];
  logic                  err_vld_q, err_vld_d;
  logic [MW-1:0]         err_mst_q, err_mst_d;

  // Address decode: lowest-numbered matching rule wins, otherwise the error responder.
  always_comb begin : decode
    logic [RULE_IDX_W-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_start, r_end, addr;
    r_idx   = '0;
    r_start = '0;
    r_end   = '0;
    addr    = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      tgt[m] = SW'(ERR_IDX);
      addr   = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
      for (int r = int'(NSLAVE) - 1; r >= 0; r--) begin
        r_idx   = addr_map_i[r*RULE_W + 2*ADDR_WIDTH +: RULE_IDX_W];
        r_start = addr_map_i[r*RULE_W + ADDR_WIDTH +: ADDR_WIDTH];
        r_end   = addr_map_i[r*RULE_W +: ADDR_WIDTH];
        if (addr >= r_start && addr < r_end && r_idx < RULE_IDX_W'(NSLAVE)) begin
          tgt[m] = SW'(r_idx);
        end
      end
    end
  end

  // Response routing from FIFO heads and the error responder.
  always_comb begin : rsp_route
    rsp_vld = '0;
    rsp_err = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      rsp_data[m] = '0;
      for (int s = 0; s < int'(NSLAVE); s++) begin
        if (s_rvalid_i[s] && !fifo_empty[s] && fifo_head[s] == MW'(m)) begin
          rsp_vld[m]  = 1'b1;
          rsp_data[m] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (err_vld_q && err_mst_q == MW'(m)) begin
        rsp_vld[m]  = 1'b1;
        rsp_err[m]  = 1'b1;
        rsp_data[m] = '0;
      end
    end
  end

  // Stall rule; a response in this cycle frees its slot for a same-cycle grant.
  always_comb begin : stall
    logic [CW-1:0] cnt_eff;
    cnt_eff = '0;
    req_ok  = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      cnt_eff   = cnt_q[m] - CW'(rsp_vld[m]);
      req_ok[m] = m_req_i[m] && !rst_i && (cnt_eff != CW'(MAX_OUTST)) &&
                  !((cnt_eff != '0) && (tgt[m] != last_tgt_q[m]));
    end
  end

  // Round-robin pick per target, starting after the last granted master.
  always_comb begin : arbiter
    int mi;
    mi      = 0;
    arb_vld = '0;
    for (int t = 0; t < int'(NT); t++) begin
      arb_sel[t] = '0;
      for (int i = 0; i < int'(NMASTER); i++) begin
        mi = (int'(rr_q[t]) + i) % int'(NMASTER);
        if (!arb_vld[t] && req_ok[mi] && tgt[mi] == SW'(t)) begin
          arb_vld[t] = 1'b1;
          arb_sel[t] = MW'(mi);
        end
      end
    end
  end

  always_comb begin : slave_chan
    s_req_o   = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    fifo_pop  = '0;
    fifo_push = '0;
    for (int s = 0; s < int'(NSLAVE); s++) begin
      fifo_pop[s]  = s_rvalid_i[s] && !fifo_empty[s] && !rst_i;
      s_req_o[s]   = arb_vld[s] && (!fifo_full[s] || fifo_pop[s]);
      fifo_push[s] = s_req_o[s] && s_gnt_i[s];
      s_we_o[s]    = m_we_i[arb_sel[s]];
      s_be_o[s*BE_W +: BE_W]                   = m_be_i[int'(arb_sel[s])*BE_W +: BE_W];
      s_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH]     = m_addr_i[int'(arb_sel[s])*ADDR_WIDTH +: ADDR_WIDTH];
      s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH]    = m_wdata_i[int'(arb_sel[s])*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin : grant
    tgt_gnt = {arb_vld[ERR_IDX], fifo_push};
    gnt     = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      for (int t = 0; t < int'(NT); t++) begin
        if (tgt_gnt[t] && arb_sel[t] == MW'(m)) gnt[m] = 1'b1;
      end
    end
    m_gnt_o = gnt;
  end

  always_comb begin : mst_out
    m_rvalid_o = rst_i ? '0 : rsp_vld;
    m_err_o    = rst_i ? '0 : rsp_err;
    m_rdata_o  = '0;
    if (!rst_i) begin
      for (int m = 0; m < int'(NMASTER); m++) m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = rsp_data[m];
    end
  end

  always_comb begin : next_state
    for (int m = 0; m < int'(NMASTER); m++) begin
      cnt_d[m]      = cnt_q[m] + CW'(gnt[m]) - CW'(rsp_vld[m]);
      last_tgt_d[m] = gnt[m] ? tgt[m] : last_tgt_q[m];
    end
    for (int t = 0; t < int'(NT); t++) begin
      rr_d[t] = tgt_gnt[t] ? MW'((int'(arb_sel[t]) + 1) % int'(NMASTER)) : rr_q[t];
    end
    err_vld_d = arb_vld[ERR_IDX];
    err_mst_d = arb_sel[ERR_IDX];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < int'(NMASTER); m++) begin
        cnt_q[m]      <= '0;
        last_tgt_q[m] <= '0;
      end
      for (int t = 0; t < int'(NT); t++) rr_q[t] <= '0;
      err_vld_q <= 1'b0;
      err_mst_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_tgt_q <= last_tgt_d;
      rr_q       <= rr_d;
      err_vld_q  <= err_vld_d;
      err_mst_q  <= err_mst_d;
    end
  end

  for (genvar s = 0; s < int'(NSLAVE); s++) begin : g_slave
    obi_xbar_idx_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (MW)
    ) u_idx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[s]),
      .pop_i   (fifo_pop[s]),
      .data_i  (arb_sel[s]),
      .head_o  (fifo_head[s]),
      .full_o  (fifo_full[s]),
      .empty_o (fifo_empty[s])
    );

    // A response with nothing outstanding is a slave protocol violation; it is dropped.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        assert (!(s_rvalid_i[s] && fifo_empty[s]))
          else $warning("obi_xbar_nm: slave %0d rvalid with no outstanding transaction, ignored", s);
      end
    end
  end

endmodule

// File: tb/tb_obi_xbar_nm.sv
// Directed bench for obi_xbar_nm: arbitration, outstanding limit, ordering, errors, reset.
module tb_obi_xbar_nm;
  import obi_xbar_nm_pkg::*;

  localparam int NM = 3;
  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int RW = RULE_IDX_W + 2 * AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*RW-1:0]  addr_map;
  logic [NM-1:0]     m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [NM*4-1:0]   m_be;
  logic [NM*AW-1:0]  m_addr_flat;
  logic [NM*DW-1:0]  m_wdata_flat, m_rdata;
  logic [NS-1:0]     s_req, s_we, s_gnt, s_rvalid;
  logic [NS*4-1:0]   s_be;
  logic [NS*AW-1:0]  s_addr;
  logic [NS*DW-1:0]  s_wdata, s_rdata_flat;
  logic [AW-1:0]     maddr  [NM];
  logic [DW-1:0]     srdata [NS];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int m = 0; m < NM; m++) begin
      m_addr_flat[m*AW +: AW]  = maddr[m];
      m_wdata_flat[m*DW +: DW] = 32'h5500_0000 | 32'(m);
    end
    for (int s = 0; s < NS; s++) s_rdata_flat[s*DW +: DW] = srdata[s];
  end

  obi_xbar_nm #(
    .NMASTER(NM), .NSLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_map_i (addr_map),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_be_i     (m_be),
    .m_addr_i   (m_addr_flat),
    .m_wdata_i  (m_wdata_flat),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .m_err_o    (m_err),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_be_o     (s_be),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata_flat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_we = '0; m_be = '1;
    s_gnt = '0; s_rvalid = '0;
    for (int m = 0; m < NM; m++) maddr[m] = '0;
    for (int s = 0; s < NS; s++) srdata[s] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    maddr[0] = 32'h0000_0000; maddr[1] = 32'h1000_0000; maddr[2] = 32'hFFFF_0000;
    m_req = 3'b111; s_gnt = '1; s_rvalid = '1;
    for (int s = 0; s < NS; s++) srdata[s] = 32'hFFFF_FFFF;
    tick();
    #2;
    checks++; if (m_gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", m_gnt); end
    checks++; if (s_req !== 6'b0) begin failures++; $display("FAIL reset_sreq got=%b exp=000000", s_req); end
    checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", m_rvalid); end
    checks++; if (m_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    int prev;
    int exp;
    logic [NM-1:0] exp_gnt;
    logic [DW-1:0] exp_data;
    do_reset();
    maddr[0] = 32'h2000_00A0; maddr[1] = 32'h2000_00B1;
    m_req = 3'b011; s_gnt[2] = 1'b1;
    prev = -1;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) m_req = '0;
      exp = c % 2;
      exp_data = (prev == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
      s_rvalid[2] = (prev >= 0);
      srdata[2] = (prev >= 0) ? exp_data : 32'h0;
      #2;
      exp_gnt = (c < 6) ? 3'(1 << exp) : 3'b000;
      checks++;
      if (m_gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, m_gnt, exp_gnt); end
      if (c < 6) begin
        checks++;
        if (s_addr[2*AW +: AW] !== maddr[exp]) begin
          failures++; $display("FAIL rr_saddr c=%0d got=%h exp=%h", c, s_addr[2*AW +: AW], maddr[exp]);
        end
      end
      if (prev >= 0) begin
        checks++;
        if (m_rvalid !== 3'(1 << prev)) begin failures++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, m_rvalid, 3'(1 << prev)); end
        checks++;
        if (m_rdata[prev*DW +: DW] !== exp_data) begin
          failures++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, m_rdata[prev*DW +: DW], exp_data);
        end
      end
      prev = (c < 6) ? exp : -1;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_outstanding();
    do_reset();
    maddr[0] = 32'h0000_0010; m_req = 3'b001; s_gnt[0] = 1'b1; srdata[0] = 32'h0000_5A5A;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (m_gnt !== 3'b001) begin failures++; $display("FAIL outst_gnt c=%0d got=%b exp=001", c, m_gnt); end
      tick();
    end
    for (int c = 4; c < 6; c++) begin
      #2;
      checks++; if (m_gnt !== 3'b000) begin failures++; $display("FAIL outst_stall c=%0d got=%b exp=000", c, m_gnt); end
      checks++; if (s_req[0] !== 1'b0) begin failures++; $display("FAIL outst_sreq c=%0d got=%b exp=0", c, s_req[0]); end
      tick();
    end
    s_rvalid[0] = 1'b1;
    #2;
    checks++; if (m_rvalid !== 3'b001) begin failures++; $display("FAIL outst_unblock_rvalid got=%b exp=001", m_rvalid); end
    checks++; if (m_gnt !== 3'b001) begin failures++; $display("FAIL outst_unblock_gnt got=%b exp=001", m_gnt); end
    checks++; if (m_rdata[0 +: DW] !== 32'h0000_5A5A) begin failures++; $display("FAIL outst_rdata got=%h exp=00005a5a", m_rdata[0 +: DW]); end
    tick();
    m_req = '0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (m_rvalid !== 3'b001) begin failures++; $display("FAIL outst_drain c=%0d got=%b exp=001", c, m_rvalid); end
      tick();
    end
    s_rvalid[0] = 1'b0;
    #2;
    checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL outst_idle got=%b exp=000", m_rvalid); end
    clear_inputs();
    tick();
  endtask

  task automatic test_ordering();
    do_reset();
    maddr[0] = 32'h1000_0004; m_req = 3'b001; s_gnt[1] = 1'b1; s_gnt[3] = 1'b1;
    #2;
    checks++; if (m_gnt !== 3'b001) begin failures++; $display("FAIL order_first_gnt got=%b exp=001", m_gnt); end
    tick();
    maddr[0] = 32'h3000_0000;
    for (int c = 1; c < 5; c++) begin
      #2;
      checks++; if (m_gnt !== 3'b000) begin failures++; $display("FAIL order_hold_gnt c=%0d got=%b exp=000", c, m_gnt); end
      checks++; if (s_req[3] !== 1'b0) begin failures++; $display("FAIL order_hold_sreq c=%0d got=%b exp=0", c, s_req[3]); end
      tick();
    end
    s_rvalid[1] = 1'b1; srdata[1] = 32'h1111_0001;
    #2;
    checks++; if (m_rvalid !== 3'b001) begin failures++; $display("FAIL order_rsp1 got=%b exp=001", m_rvalid); end
    checks++; if (m_rdata[0 +: DW] !== 32'h1111_0001) begin failures++; $display("FAIL order_rdata1 got=%h exp=11110001", m_rdata[0 +: DW]); end
    checks++; if (m_gnt !== 3'b001 || s_req[3] !== 1'b1) begin
      failures++; $display("FAIL order_release got gnt=%b sreq3=%b exp gnt=001 sreq3=1", m_gnt, s_req[3]);
    end
    tick();
    s_rvalid[1] = 1'b0; m_req = '0; s_rvalid[3] = 1'b1; srdata[3] = 32'h3333_0003;
    #2;
    checks++; if (m_rvalid !== 3'b001) begin failures++; $display("FAIL order_rsp3 got=%b exp=001", m_rvalid); end
    checks++; if (m_rdata[0 +: DW] !== 32'h3333_0003) begin failures++; $display("FAIL order_rdata3 got=%h exp=33330003", m_rdata[0 +: DW]); end
    tick();
    clear_inputs();
  endtask

  task automatic test_error();
    do_reset();
    for (int s = 0; s < NS; s++) srdata[s] = 32'hDEAD_BEEF;
    s_gnt = '1;
    maddr[2] = 32'hFFFF_0000; m_we[2] = 1'b1; m_req = 3'b100;
    #2;
    checks++; if (m_gnt !== 3'b100) begin failures++; $display("FAIL err_gnt got=%b exp=100", m_gnt); end
    checks++; if (s_req !== 6'b0) begin failures++; $display("FAIL err_sreq got=%b exp=000000", s_req); end
    checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL err_early_rvalid got=%b exp=000", m_rvalid); end
    tick();
    m_req = '0;
    #2;
    checks++; if (m_rvalid !== 3'b100 || m_err !== 3'b100) begin
      failures++; $display("FAIL err_rsp got rvalid=%b err=%b exp rvalid=100 err=100", m_rvalid, m_err);
    end
    checks++; if (m_rdata[2*DW +: DW] !== 32'h0) begin failures++; $display("FAIL err_rdata got=%h exp=0", m_rdata[2*DW +: DW]); end
    tick();
    #2;
    checks++; if (m_rvalid !== 3'b000 || m_err !== 3'b000) begin
      failures++; $display("FAIL err_single got rvalid=%b err=%b exp 000/000", m_rvalid, m_err);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_parallel();
    do_reset();
    maddr[0] = 32'h0000_0100; maddr[1] = 32'h4000_0200; m_req = 3'b011; s_gnt = '1;
    #2;
    checks++; if (m_gnt !== 3'b011) begin failures++; $display("FAIL par_gnt got=%b exp=011", m_gnt); end
    checks++; if (s_req !== 6'b010001) begin failures++; $display("FAIL par_sreq got=%b exp=010001", s_req); end
    checks++; if (s_addr[0 +: AW] !== 32'h0000_0100 || s_addr[4*AW +: AW] !== 32'h4000_0200) begin
      failures++; $display("FAIL par_saddr got s0=%h s4=%h exp 00000100/40000200", s_addr[0 +: AW], s_addr[4*AW +: AW]);
    end
    tick();
    m_req = '0; s_rvalid[0] = 1'b1; s_rvalid[4] = 1'b1; srdata[0] = 32'h0000_00C0; srdata[4] = 32'h0000_00C4;
    #2;
    checks++; if (m_rvalid !== 3'b011) begin failures++; $display("FAIL par_rvalid got=%b exp=011", m_rvalid); end
    checks++; if (m_rdata[0 +: DW] !== 32'h0000_00C0 || m_rdata[DW +: DW] !== 32'h0000_00C4) begin
      failures++; $display("FAIL par_rdata got m0=%h m1=%h exp 000000c0/000000c4", m_rdata[0 +: DW], m_rdata[DW +: DW]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    maddr[0] = 32'h0000_0020; m_req = 3'b001; s_gnt[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (m_gnt !== 3'b001) begin failures++; $display("FAIL rstmid_gnt c=%0d got=%b exp=001", c, m_gnt); end
      tick();
    end
    m_req = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    s_rvalid[0] = 1'b1; srdata[0] = 32'h0000_7777;
    #2;
    checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL rstmid_late_rvalid got=%b exp=000", m_rvalid); end
    tick();
    s_rvalid[0] = 1'b0; m_req = 3'b001;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (m_gnt !== 3'b001) begin failures++; $display("FAIL rstmid_regnt c=%0d got=%b exp=001", c, m_gnt); end
      tick();
    end
    #2;
    checks++; if (m_gnt !== 3'b000) begin failures++; $display("FAIL rstmid_limit got=%b exp=000", m_gnt); end
    tick();
    clear_inputs();
  endtask

  initial begin
    addr_rule_t rule;
    for (int i = 0; i < NS; i++) begin
      rule.idx        = 32'(i);
      rule.start_addr = 32'(i) * 32'h1000_0000;
      rule.end_addr   = 32'(i + 1) * 32'h1000_0000;
      addr_map[i*RW +: RW] = rule;
    end
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_outstanding();
    test_ordering();
    test_error();
    test_parallel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_xbar_nm.md
Name: obi_xbar_nm

Overview:
- Parametrised N-master to M-slave OBI crossbar that replaces the split N-to-1 / 1-to-N structure.
- A single shared neck serialised every master. This block instead gives each slave its own round-robin arbiter, so independent master/slave pairs proceed in parallel.
- Response routing uses per-slave index FIFOs and keeps per-master ordering safe under multiple outstanding transactions.
- Unmapped addresses go to an internal error responder. The block sits between the core/DMA/debug masters and the system slaves (memory banks, peripheral bus, accelerator).

Parameters:
- NMASTER, 3, number of master ports (>=1)
- NSLAVE, 6, number of slave ports (>=1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8); BE width = DATA_WIDTH/8
- MAX_OUTST, 4, maximum outstanding transactions per master and per slave FIFO depth (power of 2, >=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- addr_map_i  in  NSLAVE x {idx, start_addr, end_addr}  address rule per slave; a rule matches when start_addr <= addr < end_addr
- m_req_i  in  NMASTER  master request
- m_we_i  in  NMASTER  write enable
- m_be_i  in  NMASTER x DATA_WIDTH/8  byte enables
- m_addr_i  in  NMASTER x ADDR_WIDTH  address
- m_wdata_i  in  NMASTER x DATA_WIDTH  write data
- m_gnt_o  out  NMASTER  grant
- m_rvalid_o  out  NMASTER  response valid
- m_rdata_o  out  NMASTER x DATA_WIDTH  read data
- m_err_o  out  NMASTER  error response (unmapped access)
- s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o  out  NSLAVE x widths as above  slave request channel
- s_gnt_i, s_rvalid_i  in  NSLAVE  slave grant / response valid
- s_rdata_i  in  NSLAVE x DATA_WIDTH  slave read data

Behaviour:
- Reset (rst_i=1 at a clock edge), synchronous:
  - outputs: all FIFOs empty, all RR pointers 0, all outstanding counters 0.
  - m_gnt_o, m_rvalid_o, m_err_o, s_req_o all 0; rdata outputs 0.
  - A reset mid-transaction drops all in-flight bookkeeping. Slave responses arriving after reset are ignored.
- Decode (combinational): the first matching rule (lowest index) selects the target slave. No match selects the error responder.
- Master stall rule, per master m:
  - Track cnt_m (0..MAX_OUTST) and last_tgt_m.
  - The request is masked from arbitration when cnt_m==MAX_OUTST, or when cnt_m>0 and the target differs from last_tgt_m.
  - This guarantees in-order responses per master.
- Per-slave arbitration:
  - Round-robin among unmasked requesting masters. Priority starts at the index after the last granted master.
  - s_req_o=1 only when the slave's index FIFO is not full. The selected master's fields are driven combinationally.
- Grant: m_gnt_o = s_gnt_i of the target slave AND the master is selected. Zero-cycle pass-through; no registers in the request path.
- On a grant in a cycle:
  - push the master index into that slave's FIFO;
  - cnt_m++;
  - last_tgt_m <= target.
- Response routing:
  - On s_rvalid_i[s], pop the head of FIFO s and assert m_rvalid_o with rdata for that master in the same cycle (combinational). cnt_m--.
  - s_rvalid_i with FIFO s empty is a protocol violation: ignore it and flag it with an assertion.
- Same-cycle events:
  - Grant plus response on one master: cnt_m is unchanged.
  - Push plus pop on one FIFO: occupancy unchanged; a full FIFO may accept a push when a pop occurs in the same cycle.
- Error responder:
  - Grants unmapped requests immediately, in round-robin order among masters.
  - Returns m_rvalid_o=1, m_err_o=1, rdata=0 exactly one cycle after the grant. Writes are discarded.
  - It occupies one outstanding slot for that cycle.
- Only one response per master per cycle is possible, guaranteed by the stall rule.

Decomposition:
- Package obi_xbar_nm_pkg:
  - addr rule typedef;
  - ERR_IDX = NSLAVE;
  - helper function idx_width.
- Sub-module obi_xbar_idx_fifo (parameters DEPTH, WIDTH):
  - synchronous FIFO with push, pop, full, empty and head outputs;
  - supports same-cycle push and pop when full;
  - instanced once per slave.
- The round-robin arbiter is inline logic, one per slave.

Test Plan:
- Masters 0 and 1 both read slave 2 continuously, s_gnt_i=1, rvalid 1 cycle later → grants alternate 0,1,0,1. Each master receives its own rdata (0xA0/0xB1 tagged).
- Master 0 issues 4 back-to-back reads to slave 0 with MAX_OUTST=4 and rvalid held low → 4 grants, the 5th request is stalled. The first rvalid unblocks one grant in the same cycle.
- Master 0 reads slave 1 (latency 5) then requests slave 3 → slave 3 request is withheld until m_rvalid_o returns for slave 1, then granted.
- Master 2 accesses addr 0xFFFF_0000 (no rule) → m_gnt_o the same cycle. m_rvalid_o=1, m_err_o=1, rdata=0 on the next cycle; no s_req_o asserted.
- Masters 0 and 1 target slaves 0 and 4 in the same cycle → both granted in the same cycle with no interference.
- rst_i asserted with 3 outstanding on slave 0, late s_rvalid_i arrives after reset → no m_rvalid_o; cnt and FIFO stay 0.
